seq_vec_data_mem: RTL
=====================

Name: seq_vec_data_mem

Overview:
Parametrised data memory serving scalar LSU accesses (byte/half/word, sign or zero extension) and multi-lane vector loads/stores. Vector transfers are sequenced one lane per cycle over a LANE_W-wide internal port, under a ready/valid-style handshake. Sits in the MEM stage alongside the scalar LSU and the vector unit. Generalises fixed 4x128 vector storage to configurable lane count, lane width and depth.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of 2
NUM_LANES, 4, vector lanes per transfer; 1..16
LANE_W, 128, bits per lane; multiple of 32, power of 2

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
req_i  in  1  access request; sampled only when ready_o=1
wr_i  in  1  1=write, 0=read
addr_i  in  32  byte address
wr_data_i  in  32  scalar write data, right-aligned
byte_en_i  in  2  00 byte, 01 half, 11 word, 10 reserved (treated as word)
zero_extnd_i  in  1  1=zero-extend scalar reads, 0=sign-extend
is_vector_i  in  1  1=vector access (byte_en_i, zero_extnd_i ignored)
vec_wr_data_i  in  NUM_LANES x LANE_W  vector write data, unpacked array indexed by lane
ready_o  out  1  1 only in IDLE
busy_o  out  1  vector sequence in progress
rd_valid_o  out  1  one-cycle pulse: read data valid
rd_data_o  out  32  scalar read data
vec_rd_data_o  out  NUM_LANES x LANE_W  vector read data, held until next vector read completes
err_o  out  1  misalignment flag (MISALIGN_TRAP_EN only; tied 0 otherwise)

Behaviour:
- Reset (async, reset_n=0): state IDLE; ready_o=1, busy_o=0, rd_valid_o=0, rd_data_o=0, all vec_rd_data_o lanes=0, err_o=0. Memory array not reset. Reset mid-vector-op aborts the sequence; lanes already written stay written.
- Word index = addr_i[log2(DEPTH_WORDS)+1:2]; upper bits ignored (wrap modulo DEPTH_WORDS).
- Scalar write (IDLE, req_i&wr_i&!is_vector_i): commits at that edge. Byte: byte addr_i[1:0] gets wr_data_i[7:0]. Half: half addr_i[1] gets wr_data_i[15:0]. Word: full word, addr_i[1:0] ignored. Other bytes untouched. No rd_valid_o.
- Scalar read: 1-cycle latency. rd_data_o registered at the accept edge, rd_valid_o=1 next cycle. Extracted byte/half is right-aligned then zero- or sign-extended per zero_extnd_i. Back-to-back scalar accesses every cycle.
- Vector access (IDLE, req_i&is_vector_i): base = addr_i with low log2(LANE_W/8) bits cleared. For writes, all of vec_wr_data_i is latched at accept. FSM: IDLE -> VEC_XFER (beat counter 0..NUM_LANES-1) -> IDLE.
- Beat k: lane k at byte address base + k*(LANE_W/8), word indices wrap modulo DEPTH_WORDS. Write beats store LANE_W/32 words. Read beats fill vec_rd_data_o[k].
- busy_o=1 and ready_o=0 throughout VEC_XFER. Vector write takes NUM_LANES cycles. Vector read pulses rd_valid_o the cycle after the last beat; vec_rd_data_o is updated only for the read's lanes.
- req_i while ready_o=0 is ignored (not queued); the requester holds req_i until accepted.
- NUM_LANES=1: single-beat vector op, returns to IDLE after 1 cycle.

Optional Feature:
MISALIGN_TRAP_EN. Defined: a scalar half with addr_i[0]=1, a scalar word with addr_i[1:0]!=0, or a vector address with nonzero low lane-offset bits is rejected. No write occurs, no rd_valid_o, and err_o pulses 1 cycle after accept. Undefined: misaligned low bits are silently ignored as above and err_o is tied 0.

Test Plan:
- Scalar word write 0xDEADBEEF @0x10, then word read @0x10 -> rd_valid_o 1 cycle after accept, rd_data_o=0xDEADBEEF.
- Byte read @0x13, zero_extnd_i=0 -> 0xFFFFFFDE. zero_extnd_i=1 -> 0x000000DE. Half write 0x1234 @0x12 -> word read @0x10 = 0x1234BEEF.
- Vector write @0x20, lane i = 128'h1111_0000...0000+i -> busy_o high 4 cycles. Vector read @0x20 -> rd_valid_o on cycle 5 after accept, lanes match, and word read @0x30 = 0x00000001.
- req_i asserted during busy_o -> ignored, memory unchanged. After ready_o rises, the held scalar request is accepted.
- reset_n low at beat 2 of a vector write -> outputs return to reset values immediately. Lanes 0-1 written, lanes 2-3 keep old data.
- Vector write at (DEPTH_WORDS*4 - 32) -> lanes 2-3 wrap to word 0 onward. Readback matches. With MISALIGN_TRAP_EN, word read @0x11 -> err_o pulse, no rd_valid_o.

Source files
------------

// File: rtl/seq_vec_data_mem.sv
// seq_vec_data_mem: word-organised data memory shared by the scalar LSU
// (byte/half/word, sign or zero extension) and the vector unit (NUM_LANES
// lanes of LANE_W bits, moved one lane per cycle).
// Optional build macro: MISALIGN_TRAP_EN rejects misaligned accesses and
// pulses err_o. Without it, misaligned low address bits are ignored.
module seq_vec_data_mem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int NUM_LANES   = 4,
  parameter int LANE_W      = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_i,
  input  logic              wr_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wr_data_i,
  input  logic [1:0]        byte_en_i,
  input  logic              zero_extnd_i,
  input  logic              is_vector_i,
  input  logic [LANE_W-1:0] vec_wr_data_i [NUM_LANES],
  output logic              ready_o,
  output logic              busy_o,
  output logic              rd_valid_o,
  output logic [31:0]       rd_data_o,
  output logic [LANE_W-1:0] vec_rd_data_o [NUM_LANES],
  output logic              err_o
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int WPL = LANE_W / 32;
  localparam int LOB = $clog2(LANE_W / 8);
  localparam int CW  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef enum logic {S_IDLE, S_VEC} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_beat;
  logic [AW-1:0]     r_ptr;
  logic              r_vec_wr;
  logic              r_rd_valid;
  logic [31:0]       r_rd_data;
  logic [LANE_W-1:0] r_vec_rd [NUM_LANES];
  logic [LANE_W-1:0] r_wbuf   [NUM_LANES];
  logic [LANE_W-1:0] r_rbuf   [NUM_LANES];
  logic [31:0]       r_mem    [DEPTH_WORDS];

  logic              w_accept;
  logic              w_misalign;
  logic              w_sc_wr;
  logic              w_last;
  logic [AW-1:0]     w_idx;
  logic [31:0]       w_word;
  logic [31:0]       w_sh_b;
  logic [31:0]       w_sh_h;
  logic [31:0]       w_rd_ext;
  logic [31:0]       w_wmask;
  logic [31:0]       w_wdata;
  logic [LANE_W-1:0] w_lane_rd;
  logic [LANE_W-1:0] w_lane_wr;
  logic              w_unused;

  assign w_accept  = (r_state == S_IDLE) && req_i;
  assign w_idx     = addr_i[AW+1:2];
  assign w_word    = r_mem[w_idx];
  assign w_sc_wr   = w_accept && wr_i && !is_vector_i && !w_misalign;
  assign w_last    = (r_beat == CW'(NUM_LANES - 1));
  assign w_lane_wr = r_wbuf[r_beat];
  // Address bits above the word index only wrap the array.
  assign w_unused  = ^addr_i[31:AW+2];

`ifdef MISALIGN_TRAP_EN
  // Alignment rule: halves on even bytes, words on word boundaries, vectors on lane boundaries.
  always_comb begin
    w_misalign = 1'b0;
    if (is_vector_i) begin
      w_misalign = |addr_i[LOB-1:0];
    end else begin
      case (byte_en_i)
        2'b00:   w_misalign = 1'b0;
        2'b01:   w_misalign = addr_i[0];
        default: w_misalign = |addr_i[1:0];
      endcase
    end
  end
`else
  assign w_misalign = 1'b0;
`endif

  // Each lane is WPL consecutive words starting at the beat pointer, lowest word in the low bits.
  generate
    for (genvar gi = 0; gi < WPL; gi++) begin : g_lane_rd
      assign w_lane_rd[32*gi +: 32] = r_mem[r_ptr + AW'(gi)];
    end
  endgenerate

  // Scalar read extraction and scalar write byte-lane merge.
  always_comb begin
    w_sh_b   = w_word >> {addr_i[1:0], 3'b000};
    w_sh_h   = w_word >> {addr_i[1], 4'b0000};
    w_rd_ext = w_word;
    w_wmask  = 32'hFFFF_FFFF;
    w_wdata  = wr_data_i;
    case (byte_en_i)
      2'b00: begin
        w_rd_ext = {{24{w_sh_b[7] & ~zero_extnd_i}}, w_sh_b[7:0]};
        w_wmask  = 32'h0000_00FF << {addr_i[1:0], 3'b000};
        w_wdata  = {4{wr_data_i[7:0]}};
      end
      2'b01: begin
        w_rd_ext = {{16{w_sh_h[15] & ~zero_extnd_i}}, w_sh_h[15:0]};
        w_wmask  = 32'h0000_FFFF << {addr_i[1], 4'b0000};
        w_wdata  = {2{wr_data_i[15:0]}};
      end
      default: begin
        w_rd_ext = w_word;
      end
    endcase
  end

  // Storage array: scalar writes from IDLE, one lane of words per vector write beat.
  always_ff @(posedge clk) begin
    if (w_sc_wr) begin
      r_mem[w_idx] <= (w_word & ~w_wmask) | (w_wdata & w_wmask);
    end else if (r_state == S_VEC && r_vec_wr) begin
      for (int w = 0; w < WPL; w++) begin
        r_mem[r_ptr + AW'(w)] <= w_lane_wr[32*w +: 32];
      end
    end
  end

  // Vector write data captured at accept; read lanes staged until the last beat.
  always_ff @(posedge clk) begin
    if (w_accept && is_vector_i && wr_i && !w_misalign) begin
      r_wbuf <= vec_wr_data_i;
    end
    if (r_state == S_VEC && !r_vec_wr) begin
      r_rbuf[r_beat] <= w_lane_rd;
    end
  end

  // Control FSM: accepts requests in IDLE, sequences vector beats in S_VEC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_ptr      <= '0;
      r_vec_wr   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      for (int j = 0; j < NUM_LANES; j++) r_vec_rd[j] <= '0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && !w_misalign) begin
            if (is_vector_i) begin
              r_state  <= S_VEC;
              r_beat   <= '0;
              r_ptr    <= w_idx & ~AW'(WPL - 1);
              r_vec_wr <= wr_i;
            end else if (!wr_i) begin
              r_rd_data  <= w_rd_ext;
              r_rd_valid <= 1'b1;
            end
          end
        end
        default: begin
          r_ptr  <= r_ptr + AW'(WPL);
          r_beat <= r_beat + CW'(1);
          if (w_last) begin
            r_state <= S_IDLE;
            if (!r_vec_wr) begin
              r_rd_valid <= 1'b1;
              for (int j = 0; j < NUM_LANES; j++) begin
                r_vec_rd[j] <= (r_beat == CW'(j)) ? w_lane_rd : r_rbuf[j];
              end
            end
          end
        end
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic r_err;
  // Misaligned request flagged for exactly one cycle after its accept edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_err <= 1'b0;
    else          r_err <= w_accept && w_misalign;
  end
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign ready_o       = (r_state == S_IDLE);
  assign busy_o        = (r_state == S_VEC);
  assign rd_valid_o    = r_rd_valid;
  assign rd_data_o     = r_rd_data;
  assign vec_rd_data_o = r_vec_rd;

endmodule
